jedro_1_regcheck: RTL and testbench

JEDRO_1_REGCHECK -- requirements
Module: jedro_1_regcheck

---
 rtl/jedro_1_regcheck_pkg.sv | 14 +
 rtl/jedro_1_regcheck.sv | 123 ++++++++++++
 tb/tb_jedro_1_regcheck.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/jedro_1_regcheck_pkg.sv
// jedro_1_regcheck_pkg: FSM state encoding and default sizing for the register-file checker.
package jedro_1_regcheck_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_CHECK,
    S_DONE
  } state_t;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_NUM_REGS     = 32;
  localparam int DEF_DRAIN_CYCLES = 3;
  localparam int DEF_MAX_CYCLES   = 32;
endpackage

// File: rtl/jedro_1_regcheck.sv
// jedro_1_regcheck: waits for core halt, drains, then compares the register file against expected values.
// Define JEDRO_1_REGCHECK_TIMEOUT_EN to bound the run phase by MAX_CYCLES and report timeout_o.
module jedro_1_regcheck
  import jedro_1_regcheck_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_REGS     = DEF_NUM_REGS,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int MAX_CYCLES   = DEF_MAX_CYCLES
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           start_i,
  input  logic                           halt_i,
  output logic [$clog2(NUM_REGS)-1:0]    rf_raddr_o,
  input  logic [DATA_WIDTH-1:0]          rf_rdata_i,
  input  logic [NUM_REGS-1:0]            exp_mask_i,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] exp_data_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           pass_o,
  output logic                           timeout_o,
  output logic [$clog2(NUM_REGS+1)-1:0]  err_cnt_o,
  output logic [$clog2(NUM_REGS)-1:0]    err_addr_o,
  output logic [DATA_WIDTH-1:0]          err_data_o
);
  localparam int IW = $clog2(NUM_REGS);
  localparam int EW = $clog2(NUM_REGS + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic [DW-1:0]         r_drain;
  logic [EW-1:0]         r_err_cnt;
  logic [IW-1:0]         r_err_addr;
  logic [DATA_WIDTH-1:0] r_err_data;
  logic                  r_done;
  logic                  r_pass;
  logic                  w_start;
  logic                  w_mismatch;
  logic                  w_run_end;
  logic                  w_timeout;
  assign w_start    = (r_state == S_IDLE || r_state == S_DONE) && start_i;
  assign w_mismatch = exp_mask_i[r_idx] && rf_rdata_i != exp_data_i[r_idx*DATA_WIDTH +: DATA_WIDTH];
`ifdef JEDRO_1_REGCHECK_TIMEOUT_EN
  localparam int CW = $clog2(MAX_CYCLES);
  logic [CW-1:0] r_cnt;
  logic          r_timeout;
  assign w_timeout = r_timeout;
  assign w_run_end = halt_i || r_cnt == CW'(MAX_CYCLES - 1);
  // halt in the final budget cycle takes priority, so timeout only latches when halt is low
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (w_start) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + CW'(1);
      if (!halt_i && r_cnt == CW'(MAX_CYCLES - 1)) r_timeout <= 1'b1;
    end
`else
  assign w_timeout = 1'b0;
  assign w_run_end = halt_i;
`endif
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_drain    <= '0;
      r_err_cnt  <= '0;
      r_err_addr <= '0;
      r_err_data <= '0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE:
          if (start_i) begin
            r_state    <= S_RUN;
            r_err_cnt  <= '0;
            r_err_addr <= '0;
            r_err_data <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
          end
        S_RUN:
          if (w_run_end) begin
            r_state <= S_DRAIN;
            r_drain <= '0;
          end
        S_DRAIN:
          if (r_drain == DW'(DRAIN_CYCLES - 1)) begin
            r_state <= S_CHECK;
            r_idx   <= '0;
          end else r_drain <= r_drain + DW'(1);
        S_CHECK: begin
          if (w_mismatch) begin
            if (r_err_cnt != EW'(NUM_REGS)) r_err_cnt <= r_err_cnt + EW'(1);
            // a zero count means nothing has been captured yet this run
            if (r_err_cnt == '0) begin
              r_err_addr <= r_idx;
              r_err_data <= rf_rdata_i;
            end
          end
          if (r_idx == IW'(NUM_REGS - 1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_pass  <= r_err_cnt == '0 && !w_mismatch && !w_timeout;
          end else r_idx <= r_idx + IW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  assign rf_raddr_o = r_state == S_CHECK ? r_idx : '0;
  assign busy_o     = r_state == S_RUN || r_state == S_DRAIN || r_state == S_CHECK;
  assign done_o     = r_done;
  assign pass_o     = r_pass;
  assign timeout_o  = w_timeout;
  assign err_cnt_o  = r_err_cnt;
  assign err_addr_o = r_err_addr;
  assign err_data_o = r_err_data;
endmodule

// File: tb/tb_jedro_1_regcheck.sv
// tb_jedro_1_regcheck: directed and randomized runs of jedro_1_regcheck against a phase-length reference model.
// Honours JEDRO_1_REGCHECK_TIMEOUT_EN the same way the design does.
module tb_jedro_1_regcheck;
  localparam int NR = 32;
  localparam int DW = 32;
  localparam int DR = 3;
  localparam int MC = 32;
`ifdef JEDRO_1_REGCHECK_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic halt = 1'b0;
  logic [4:0] raddr;
  logic [DW-1:0] rdata;
  logic [NR-1:0] mask = '0;
  logic [NR*DW-1:0] expf = '0;
  logic busy, done, pass, tmo;
  logic [5:0] ecnt;
  logic [4:0] eaddr;
  logic [DW-1:0] edata;
  logic [DW-1:0] rf [NR];
  int tests = 0;
  int fails = 0;
  assign rdata = rf[raddr];
  always #5 clk = ~clk;
  jedro_1_regcheck #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .DRAIN_CYCLES(DR), .MAX_CYCLES(MC)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .halt_i(halt),
    .rf_raddr_o(raddr), .rf_rdata_i(rdata), .exp_mask_i(mask), .exp_data_i(expf),
    .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(tmo),
    .err_cnt_o(ecnt), .err_addr_o(eaddr), .err_data_o(edata)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_timeout"}, tmo, 0);
    chk({tag, "_err_cnt"}, ecnt, 0);
    chk({tag, "_err_addr"}, eaddr, 0);
    chk({tag, "_err_data"}, edata, 0);
    chk({tag, "_raddr"}, raddr, 0);
  endtask
  // h = RUN-cycle index (0 = first cycle after start) on which halt pulses; negative = never
  task automatic do_run(input string tag, input int h);
    int rl, tot, cnt, fa;
    logic [DW-1:0] fd;
    bit tm;
    tm  = TEN && (h < 0 || h > MC - 1);
    rl  = tm ? MC : h + 1;
    tot = rl + DR + NR;
    cnt = 0;
    fa  = 0;
    fd  = '0;
    for (int i = 0; i < NR; i++)
      if (mask[i] && rf[i] !== expf[i*DW +: DW]) begin
        if (cnt == 0) begin
          fa = i;
          fd = rf[i];
        end
        cnt++;
      end
    if (cnt > NR) cnt = NR;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    halt = (h == 0);
    for (int k = 0; k <= tot; k++) begin
      @(negedge clk);
      chk({tag, "_busy"}, busy, k < tot);
      chk({tag, "_done"}, done, k >= tot);
      chk({tag, "_timeout"}, tmo, tm && k >= rl);
      chk({tag, "_raddr"}, raddr, (k >= rl + DR && k < tot) ? k - rl - DR : 0);
      if (k == 0) chk({tag, "_cnt_clear"}, ecnt, 0);
      @(posedge clk);
      #1 halt = (k + 1 == h);
    end
    halt = 1'b0;
    chk({tag, "_err_cnt"}, ecnt, cnt);
    chk({tag, "_err_addr"}, eaddr, fa);
    chk({tag, "_err_data"}, edata, fd);
    chk({tag, "_pass"}, pass, cnt == 0 && !tm);
    chk({tag, "_done_hold"}, done, 1);
  endtask
  task automatic load_sub_program();
    mask = '0;
    for (int i = 0; i < NR; i++) begin
      expf[i*DW +: DW] = $urandom;
      rf[i] = $urandom;
    end
    mask[1] = 1'b1; expf[1*DW +: DW]  = 32'h0000_0002;
    mask[2] = 1'b1; expf[2*DW +: DW]  = 32'hFFFF_FFFE;
    mask[3] = 1'b1; expf[3*DW +: DW]  = 32'h0000_0000;
    mask[4] = 1'b1; expf[4*DW +: DW]  = 32'hFFFF_FFFE;
    mask[10] = 1'b1; expf[10*DW +: DW] = 32'hFFFF_FFFB;
    for (int i = 0; i < NR; i++) if (mask[i]) rf[i] = expf[i*DW +: DW];
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < NR; i++) rf[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("no_autostart_busy", busy, 0);
    load_sub_program();
    do_run("sub_match", 10);
    rf[10] = 32'hFFFF_FFFC;
    rf[2]  = 32'h0;
    do_run("sub_mismatch", 10);
    load_sub_program();
    do_run("halt_last_cycle", MC - 1);
`ifdef JEDRO_1_REGCHECK_TIMEOUT_EN
    do_run("timeout", -1);
`else
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("no_halt_busy", busy, 1);
    chk("no_halt_done", done, 0);
    rstn = 1'b0;
    @(negedge clk) rstn = 1'b1;
`endif
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    halt = 1'b1;
    @(posedge clk);
    #1 halt = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("mid_check_raddr", raddr, 5);
    rstn = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk) rstn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post_reset_idle", busy, 0);
    rf[3] = 32'h1234_5678;
    do_run("fresh_after_reset", 4);
    mask = '1;
    for (int i = 0; i < NR; i++) rf[i] = ~expf[i*DW +: DW];
    do_run("all_mismatch", 2);
    for (int n = 0; n < 5; n++) begin
      mask = $urandom;
      for (int i = 0; i < NR; i++) begin
        expf[i*DW +: DW] = $urandom;
        rf[i] = ($urandom_range(0, 3) == 0) ? $urandom : expf[i*DW +: DW];
      end
      do_run("random", $urandom_range(0, 40));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
